// File: rtl/reg_sequencer_if.sv
// Command handshake and universal-register drive bundle for reg_sequencer.
interface reg_sequencer_if #(parameter int DATA_W = 8);
  logic              CmdValid;
  logic              CmdReady;
  logic [1:0]        CmdOp;
  logic [DATA_W-1:0] CmdData;
  logic [3:0]        CmdCount;
  logic              CmdFill;
  logic              RegSerialOut;
  logic [1:0]        RegisterMode;
  logic [DATA_W-1:0] LoadSignal;
  logic              SerialInput;
  logic [DATA_W-1:0] CapData;
  logic              Done;

  modport master (
    output CmdValid, CmdOp, CmdData, CmdCount, CmdFill, RegSerialOut,
    input  CmdReady, RegisterMode, LoadSignal, SerialInput, CapData, Done
  );

  modport slave (
    input  CmdValid, CmdOp, CmdData, CmdCount, CmdFill, RegSerialOut,
    output CmdReady, RegisterMode, LoadSignal, SerialInput, CapData, Done
  );
endinterface

// File: rtl/reg_sequencer.sv
// Sequences an external universal shift/increment/load register from single commands.
// state | meaning
// IDLE  | ready for a command
// LOAD  | drive parallel load for one cycle
// SHIFT | shift right N cycles, capturing the serial output
// INC   | increment N cycles
// DONE  | one-cycle completion pulse
module reg_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           clr,
  reg_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_INC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_fill;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_load;
  logic              r_sin;
  logic [DATA_W-1:0] r_cap;
  logic              r_done;

  logic              w_accept;
  logic [3:0]        w_eff_cnt;
  logic [1:0]        w_mode_nxt;
  logic [DATA_W-1:0] w_load_nxt;
  logic              w_sin_nxt;

  assign w_accept  = bus.CmdValid && (r_state == S_IDLE);
  assign w_eff_cnt = ((bus.CmdCount == 4'd0) || (bus.CmdCount > 4'd8)) ? 4'd8 : bus.CmdCount;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Outputs are computed from the next state and registered, so they never glitch.
  always_comb begin
    w_next     = r_state;
    w_mode_nxt = 2'b00;
    w_load_nxt = '0;
    w_sin_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.CmdOp)
            2'b11:   w_next = S_LOAD;
            2'b01:   w_next = S_SHIFT;
            2'b10:   w_next = S_INC;
            default: w_next = S_DONE;
          endcase
        end
      end
      S_LOAD:          w_next = S_DONE;
      S_SHIFT, S_INC:  if (r_cnt <= 4'd1) w_next = S_DONE;
      S_DONE:          w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
    case (w_next)
      S_LOAD: begin
        w_mode_nxt = 2'b11;
        w_load_nxt = bus.CmdData;  // LOAD is only entered straight from an accept
      end
      S_SHIFT: begin
        w_mode_nxt = 2'b01;
        w_sin_nxt  = (r_state == S_IDLE) ? bus.CmdFill : r_fill;
      end
      S_INC:   w_mode_nxt = 2'b10;
      default: w_mode_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt  <= 4'd0;
      r_fill <= 1'b0;
      r_mode <= 2'b00;
      r_load <= '0;
      r_sin  <= 1'b0;
      r_cap  <= '0;
      r_done <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_load <= w_load_nxt;
      r_sin  <= w_sin_nxt;
      r_done <= (w_next == S_DONE);
      if (w_accept) begin
        r_fill <= bus.CmdFill;
        r_cnt  <= (bus.CmdOp == 2'b01 || bus.CmdOp == 2'b10) ? w_eff_cnt : 4'd0;
        if (bus.CmdOp == 2'b01) r_cap <= '0;
      end else if (r_state == S_SHIFT || r_state == S_INC) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_state == S_SHIFT) r_cap <= {bus.RegSerialOut, r_cap[DATA_W-1:1]};
      end
    end
  end

  assign bus.CmdReady     = (r_state == S_IDLE) && !clr;
  assign bus.RegisterMode = r_mode;
  assign bus.LoadSignal   = r_load;
  assign bus.SerialInput  = r_sin;
  assign bus.CapData      = r_cap;
  assign bus.Done         = r_done;

endmodule

// File: tb/tb_reg_sequencer.sv
// Directed bench for reg_sequencer with a behavioural model of the driven register.
module tb_reg_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  logic [7:0] ureg = 8'h00;

  reg_sequencer_if #(.DATA_W(8)) bus();

  reg_sequencer #(.DATA_W(8)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    case (bus.RegisterMode)
      2'b01:   ureg <= {bus.SerialInput, ureg[7:1]};
      2'b10:   ureg <= ureg + 8'd1;
      2'b11:   ureg <= bus.LoadSignal;
      default: ureg <= ureg;
    endcase
  end
  assign bus.RegSerialOut = ureg[0];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command, return just after the accepting edge with inputs scrambled.
  task automatic issue(input logic [1:0] op, input logic [7:0] data,
                       input logic [3:0] cnt, input logic fill);
    chk("ready_before_issue", {7'd0, bus.CmdReady}, 8'd1);
    bus.CmdValid = 1'b1;
    bus.CmdOp    = op;
    bus.CmdData  = data;
    bus.CmdCount = cnt;
    bus.CmdFill  = fill;
    tick();
    bus.CmdValid = 1'b0;
    bus.CmdOp    = 2'b11;
    bus.CmdData  = ~data;
    bus.CmdCount = 4'd1;
    bus.CmdFill  = ~fill;
    chk("ready_busy", {7'd0, bus.CmdReady}, 8'd0);
  endtask

  task automatic do_load(input logic [7:0] d);
    issue(2'b11, d, 4'd0, 1'b0);
    chk("load_mode", {6'd0, bus.RegisterMode}, 8'h03);
    chk("load_value", bus.LoadSignal, d);
    chk("load_done_early", {7'd0, bus.Done}, 8'd0);
    tick();
    chk("load_done", {7'd0, bus.Done}, 8'd1);
    chk("load_signal_cleared", bus.LoadSignal, 8'h00);
    chk("load_mode_done", {6'd0, bus.RegisterMode}, 8'h00);
    chk("load_reg", ureg, d);
    tick();
    chk("load_done_pulse_end", {7'd0, bus.Done}, 8'd0);
    chk("load_ready_again", {7'd0, bus.CmdReady}, 8'd1);
  endtask

  // Check n busy cycles of mode m, then the DONE cycle, then return to IDLE.
  task automatic run_n(input int n, input logic [1:0] m, input logic sin);
    for (int i = 0; i < n; i++) begin
      chk("busy_mode", {6'd0, bus.RegisterMode}, {6'd0, m});
      chk("busy_sin", {7'd0, bus.SerialInput}, {7'd0, sin});
      chk("busy_done", {7'd0, bus.Done}, 8'd0);
      chk("busy_load", bus.LoadSignal, 8'h00);
      tick();
    end
    chk("end_done", {7'd0, bus.Done}, 8'd1);
    chk("end_mode", {6'd0, bus.RegisterMode}, 8'h00);
    chk("end_sin", {7'd0, bus.SerialInput}, 8'd0);
  endtask

  initial begin
    bus.CmdValid = 1'b0;
    bus.CmdOp    = 2'b00;
    bus.CmdData  = 8'h00;
    bus.CmdCount = 4'd0;
    bus.CmdFill  = 1'b0;
    #12;
    chk("rst_ready", {7'd0, bus.CmdReady}, 8'd0);
    chk("rst_mode", {6'd0, bus.RegisterMode}, 8'h00);
    chk("rst_load", bus.LoadSignal, 8'h00);
    chk("rst_sin", {7'd0, bus.SerialInput}, 8'd0);
    chk("rst_cap", bus.CapData, 8'h00);
    chk("rst_done", {7'd0, bus.Done}, 8'd0);
    tick();
    clr = 1'b0;
    #1;
    chk("ready_after_rst", {7'd0, bus.CmdReady}, 8'd1);

    // Load 0xA5
    do_load(8'hA5);

    // Full shift, count 0 -> 8, fill 1
    issue(2'b01, 8'h00, 4'd0, 1'b1);
    chk("shift_cap_cleared", bus.CapData, 8'h00);
    run_n(8, 2'b01, 1'b1);
    chk("full_shift_cap", bus.CapData, 8'hA5);
    chk("full_shift_reg", ureg, 8'hFF);
    tick();
    chk("full_shift_cap_held", bus.CapData, 8'hA5);

    // Partial shift of 0x3C by 3, fill 0
    do_load(8'h3C);
    chk("cap_held_over_load", bus.CapData, 8'hA5);
    issue(2'b01, 8'h00, 4'd3, 1'b0);
    run_n(3, 2'b01, 1'b0);
    chk("part_shift_cap", bus.CapData, 8'h80);
    chk("part_shift_reg", ureg, 8'h07);
    tick();

    // Increment 0xFE by 3 wraps to 0x01
    do_load(8'hFE);
    issue(2'b10, 8'h00, 4'd3, 1'b0);
    run_n(3, 2'b10, 1'b0);
    chk("inc_wrap_reg", ureg, 8'h01);
    chk("inc_cap_untouched", bus.CapData, 8'h80);
    tick();

    // Count 12 saturates to 8
    do_load(8'h10);
    issue(2'b10, 8'h00, 4'd12, 1'b0);
    run_n(8, 2'b10, 1'b0);
    chk("inc_sat_reg", ureg, 8'h18);
    tick();

    // Hold completes in one cycle
    issue(2'b00, 8'h00, 4'd5, 1'b0);
    chk("hold_done", {7'd0, bus.Done}, 8'd1);
    chk("hold_mode", {6'd0, bus.RegisterMode}, 8'h00);
    chk("hold_reg", ureg, 8'h18);
    tick();
    chk("hold_idle", {7'd0, bus.CmdReady}, 8'd1);

    // Busy: second command during SHIFT is dropped
    do_load(8'h96);
    issue(2'b01, 8'h00, 4'd0, 1'b0);
    tick();
    bus.CmdValid = 1'b1;
    bus.CmdOp    = 2'b11;
    bus.CmdData  = 8'hFF;
    #1;
    chk("busy_ready_low", {7'd0, bus.CmdReady}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_ready_hold", {7'd0, bus.CmdReady}, 8'd0);
      chk("busy_still_shift", {6'd0, bus.RegisterMode}, 8'h01);
    end
    bus.CmdValid = 1'b0;
    run_n(4, 2'b01, 1'b0);
    chk("busy_cap", bus.CapData, 8'h96);
    chk("busy_reg", ureg, 8'h00);
    tick();

    // Reset during SHIFT cycle 4
    do_load(8'h3C);
    issue(2'b01, 8'h00, 4'd0, 1'b1);
    tick();
    tick();
    tick();
    chk("pre_abort_mode", {6'd0, bus.RegisterMode}, 8'h01);
    clr = 1'b1;
    #1;
    chk("abort_mode", {6'd0, bus.RegisterMode}, 8'h00);
    chk("abort_sin", {7'd0, bus.SerialInput}, 8'd0);
    chk("abort_cap", bus.CapData, 8'h00);
    chk("abort_done", {7'd0, bus.Done}, 8'd0);
    chk("abort_ready", {7'd0, bus.CmdReady}, 8'd0);
    #2;
    clr = 1'b0;
    #1;
    chk("abort_ready_after", {7'd0, bus.CmdReady}, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", {7'd0, bus.Done}, 8'd0);
      chk("abort_idle_mode", {6'd0, bus.RegisterMode}, 8'h00);
    end
    do_load(8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_sequencer.md
REG_SEQUENCER -- requirements
Module: reg_sequencer

Interface
REQ-001 Parameter: DATA_W, 8, width of the universal register being driven; only 8 is supported.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 CmdValid  input  1  command offered.
REQ-005 CmdReady  output  1  command accepted when CmdValid&CmdReady at a rising edge.
REQ-006 CmdOp  input  2  operation: 00 hold, 01 shift-out, 10 increment, 11 load.
REQ-007 CmdData  input  8  byte to load; used by op 11 only.
REQ-008 CmdCount  input  4  repeat count for ops 01/10; 0 means 8; values 9..15 saturate to 8.
REQ-009 CmdFill  input  1  bit shifted into the register MSB during op 01.
REQ-010 RegSerialOut  input  1  register LSB (SerialOutput) fed back.
REQ-011 RegisterMode  output  2  mode to the register: 00 hold, 01 shift right, 10 increment, 11 load.
REQ-012 LoadSignal  output  8  parallel load value to the register.
REQ-013 SerialInput  output  1  serial fill bit to the register.
REQ-014 CapData  output  8  bits captured from RegSerialOut during the last shift-out.
REQ-015 Done  output  1  one-cycle pulse when a command completes.

Function
REQ-016 FSM states: IDLE, LOAD, SHIFT, INC, DONE; CmdReady SHALL equal (state==IDLE) and SHALL be 0 while clr is high.
REQ-017 On acceptance, CmdOp/CmdData/CmdFill/effective count latch; next state is LOAD (11), SHIFT (01), INC (10) or DONE (00).
REQ-018 RegisterMode SHALL be a registered function of state: IDLE/DONE 00, LOAD 11, SHIFT 01, INC 10; no glitches.
REQ-019 LOAD lasts exactly 1 cycle with LoadSignal = latched CmdData; LoadSignal SHALL be 0 in every other state.
REQ-020 SHIFT lasts exactly N cycles (N = effective count, 1..8); SerialInput = latched CmdFill in SHIFT, 0 otherwise.
REQ-021 Each SHIFT-cycle edge: CapData <= {RegSerialOut, CapData[7:1]}; CapData SHALL clear to 0 on acceptance of an op 01 and is otherwise held.
REQ-022 After 8 shifts CapData equals the register contents before the command; after N<8 shifts the captured bits occupy CapData[7:8-N].
REQ-023 INC lasts exactly N cycles; the register increment wraps 0xFF->0x00 with no indication from this block.
REQ-024 Every command passes through DONE for exactly 1 cycle with Done=1, then IDLE; command-to-next-acceptance gap is one cycle after Done.
REQ-025 Latency from acceptance edge to Done: load 2 cycles, shift/inc N+1 cycles, hold 1 cycle.
REQ-026 CmdValid while busy SHALL be ignored (no queueing); CmdData/CmdOp changes after acceptance SHALL have no effect.

Reset
REQ-027 clr high SHALL immediately force state IDLE, RegisterMode 00, LoadSignal 0x00, SerialInput 0, CapData 0x00, Done 0, counters 0.
REQ-028 clr mid-command aborts it with no Done pulse; first command is accepted at the first rising edge after clr falls with CmdValid high.

Verification
REQ-029 Load: CmdOp=11, CmdData=0xA5 -> RegisterMode=11 and LoadSignal=0xA5 for 1 cycle, Done 2 cycles after acceptance, register reads 0xA5.
REQ-030 Full shift: register 0xA5, CmdOp=01, CmdCount=0, CmdFill=1 -> 8 cycles of mode 01, CapData=0xA5, register=0xFF, Done at cycle 9.
REQ-031 Partial shift: register 0x3C, CmdCount=3, CmdFill=0 -> CapData=0x80 (bits 100 in [7:5]), register=0x07.
REQ-032 Increment wrap: register 0xFE, CmdOp=10, CmdCount=3 -> 3 cycles of mode 10, register=0x01, Done at cycle 4.
REQ-033 Busy/ignore: second CmdValid during SHIFT -> CmdReady=0, command dropped, first command's CapData unaffected.
REQ-034 Reset mid-op: clr pulsed on SHIFT cycle 4 -> outputs to reset values asynchronously, no Done, next load 0x5A completes normally.
